a2d_spi_resp: RTL

// - Synthesizable SPI responder (slave end) emulating the 8-channel, 12-bit A2D read by A2D_intf.
// - Lets the Segway top be closed-loop simulated or FPGA-emulated without the real converter.
// - Channel samples come in as a parallel bus. The host's 16-bit command selects the channel.
// - That channel's data is returned in the NEXT frame (converter pipeline behaviour).

---
 rtl/a2d_spi_resp.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/a2d_spi_resp.sv
// a2d_spi_resp
// SPI responder that emulates an 8-channel, 12-bit A2D converter.
//
// Behaviour
// - The host's 16-bit command selects a channel (command bits [13:11]).
// - That channel is returned in the following frame, which mirrors the
//   converter's one-frame pipeline.
// - SCLK idles high.
// - The command is sampled on SCLK rise.
// - Response bits advance on SCLK fall.
// - All pin inputs are synchronised, so every internal action lands 3 clk
//   after the pin edge.
module a2d_spi_resp #(
    parameter logic [2:0] CH_RST = 3'd0,
    parameter logic [3:0] FILL   = 4'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [95:0] chan_data,
    output logic [15:0] cmd,
    output logic        cmd_vld,
    output logic        frm_err,
    output logic [2:0]  ch_sel
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_reg;

    // Synchronisers. Index 0 is the pin-side flop; index 2 is the extra
    // flop used only for edge detection.
    logic [2:0]  ss_n_sync_reg;
    logic [2:0]  sclk_sync_reg;
    logic [1:0]  mosi_sync_reg;

    logic [15:0] tx_shft_reg;
    logic [15:0] rx_shft_reg;
    logic [4:0]  bit_cnt_reg;

    // Post-reset qualification.
    // - The sync chain resets high, so if SS_n is already low at release
    //   the chain would present a fake falling edge.
    // - Frames are therefore only accepted once SS_n has genuinely been
    //   seen high.
    logic [1:0]  init_cnt_reg;
    logic        armed_reg;

    // A falling SS_n seen during the single DONE cycle is remembered and
    // serviced in the following IDLE cycle.
    logic        fall_pend_reg;

    logic        ss_fall;
    logic        ss_rise;
    logic        sclk_rise;
    logic        sclk_fall;
    logic        mosi_sync;
    logic        ss_n_low;

    // Per-channel view of the packed sample bus.
    logic [11:0] chan_arr [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi = gi + 1) begin : g_chan
            assign chan_arr[gi] = chan_data[gi*12 +: 12];
        end
    endgenerate

    assign ss_n_low  = ~ss_n_sync_reg[1];
    assign ss_fall   = ss_n_sync_reg[2] & ~ss_n_sync_reg[1];
    assign ss_rise   = ~ss_n_sync_reg[2] & ss_n_sync_reg[1];
    assign sclk_rise = ~sclk_sync_reg[2] & sclk_sync_reg[1];
    assign sclk_fall = sclk_sync_reg[2] & ~sclk_sync_reg[1];
    assign mosi_sync = mosi_sync_reg[1];

    // Pin synchronisers. SS_n and SCLK reset to their idle level (high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_n_sync_reg <= 3'b111;
            sclk_sync_reg <= 3'b111;
            mosi_sync_reg <= 2'b00;
        end else begin
            ss_n_sync_reg <= {ss_n_sync_reg[1:0], SS_n};
            sclk_sync_reg <= {sclk_sync_reg[1:0], SCLK};
            mosi_sync_reg <= {mosi_sync_reg[0], MOSI};
        end
    end

    // Arm frame detection once the sync chain holds real pin samples and
    // SS_n has been observed high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_cnt_reg <= 2'd0;
            armed_reg    <= 1'b0;
        end else begin
            if (init_cnt_reg != 2'd3) begin
                init_cnt_reg <= init_cnt_reg + 2'd1;
            end
            if ((init_cnt_reg >= 2'd2) && ss_n_sync_reg[1]) begin
                armed_reg <= 1'b1;
            end
        end
    end

    // Frame state machine with registered outputs.
    // - It owns the shift registers, the bit counter, the command/channel
    //   registers, MISO and the completion pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            tx_shft_reg   <= 16'h0000;
            rx_shft_reg   <= 16'h0000;
            bit_cnt_reg   <= 5'd0;
            fall_pend_reg <= 1'b0;
            MISO          <= 1'b0;
            cmd           <= 16'h0000;
            cmd_vld       <= 1'b0;
            frm_err       <= 1'b0;
            ch_sel        <= CH_RST;
        end else begin
            cmd_vld <= 1'b0;
            frm_err <= 1'b0;
            case (state_reg)
                IDLE: begin
                    fall_pend_reg <= 1'b0;
                    MISO          <= 1'b0;
                    if (armed_reg && ss_n_low &&
                        (ss_n_sync_reg[2] || fall_pend_reg)) begin
                        // Snapshot the selected channel now, so later bus
                        // changes cannot tear the word being sent.
                        tx_shft_reg <= {FILL, chan_arr[ch_sel]};
                        MISO        <= FILL[3];
                        rx_shft_reg <= 16'h0000;
                        bit_cnt_reg <= 5'd0;
                        state_reg   <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (ss_rise) begin
                        MISO      <= 1'b0;
                        state_reg <= DONE;
                        if (bit_cnt_reg == 5'd16) begin
                            cmd     <= rx_shft_reg;
                            ch_sel  <= rx_shft_reg[13:11];
                            cmd_vld <= 1'b1;
                        end else begin
                            frm_err <= 1'b1;
                        end
                    end else if (sclk_rise) begin
                        rx_shft_reg <= {rx_shft_reg[14:0], mosi_sync};
                        if (bit_cnt_reg != 5'd31) begin
                            bit_cnt_reg <= bit_cnt_reg + 5'd1;
                        end
                    end else if (sclk_fall) begin
                        tx_shft_reg <= {tx_shft_reg[14:0], 1'b0};
                        MISO        <= tx_shft_reg[14];
                    end
                end

                DONE: begin
                    MISO      <= 1'b0;
                    state_reg <= IDLE;
                    if (ss_fall) begin
                        fall_pend_reg <= 1'b1;
                    end
                end

                default: begin
                    MISO      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
